data_sram_responder: RTL and testbench

//  Memory-side responder for the CPU data SRAM interface driven by the EXE stage
//  (data_sram_en/we/addr/wdata); returns data_sram_rdata to the MEM stage.

---
 rtl/data_sram_responder_pkg.sv | 33 +++
 rtl/data_sram_responder_sram.sv | 33 +++
 rtl/data_sram_responder.sv | 111 +++++++++++
 tb/tb_data_sram_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared data SRAM widths, request classes and byte-merge helper
package data_sram_responder_pkg;

  localparam int DATA_SRAM_ADDR_W = 32;
  localparam int DATA_SRAM_DATA_W = 32;
  localparam int DATA_SRAM_STRB_W = 4;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_LOAD  = 2'd1,
    REQ_STORE = 2'd2
  } req_class_e;

  function automatic req_class_e classify_req(input logic en,
                                              input logic [DATA_SRAM_STRB_W-1:0] we);
    if (!en) return REQ_IDLE;
    if (we == '0) return REQ_LOAD;
    return REQ_STORE;
  endfunction

  // Byte i comes from the forwarded store data when its mask bit is set, else from the array.
  function automatic logic [DATA_SRAM_DATA_W-1:0] merge_bytes(
      input logic [DATA_SRAM_STRB_W-1:0] mask,
      input logic [DATA_SRAM_DATA_W-1:0] fwd,
      input logic [DATA_SRAM_DATA_W-1:0] arr);
    logic [DATA_SRAM_DATA_W-1:0] r;
    for (int i = 0; i < DATA_SRAM_STRB_W; i++) begin
      r[8*i +: 8] = mask[i] ? fwd[8*i +: 8] : arr[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_responder_sram.sv
// rtl/data_sram_responder_sram.sv - single-port byte-enable RAM with registered read
module sram_1rw_be
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic [DATA_SRAM_STRB_W-1:0] we,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [DATA_SRAM_DATA_W-1:0] wdata,
  output logic [DATA_SRAM_DATA_W-1:0] rdata
);

  logic [DATA_SRAM_DATA_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_SRAM_DATA_W-1:0] rdata_q;

  // Read data only changes on a read access, so it holds across write-only cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we == '0) begin
        rdata_q <= mem[addr];
      end else begin
        for (int i = 0; i < DATA_SRAM_STRB_W; i++) begin
          if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder: array plus one-entry store buffer with load forwarding
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        data_sram_en,
  input  logic [DATA_SRAM_STRB_W-1:0] data_sram_we,
  input  logic [DATA_SRAM_ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_SRAM_DATA_W-1:0] data_sram_wdata,
  output logic [DATA_SRAM_DATA_W-1:0] data_sram_rdata,
  output logic                        stb_valid
);

  req_class_e                  req;
  logic [ADDR_WIDTH-1:0]       idx;
  logic                        drain;

  logic                        ram_en;
  logic [DATA_SRAM_STRB_W-1:0] ram_we;
  logic [ADDR_WIDTH-1:0]       ram_addr;
  logic [DATA_SRAM_DATA_W-1:0] ram_rdata;
  logic [DATA_SRAM_DATA_W-1:0] merged;

  logic                        stb_valid_q, stb_valid_d;
  logic [ADDR_WIDTH-1:0]       stb_idx_q, stb_idx_d;
  logic [DATA_SRAM_STRB_W-1:0] stb_strb_q, stb_strb_d;
  logic [DATA_SRAM_DATA_W-1:0] stb_data_q, stb_data_d;
  logic [DATA_SRAM_STRB_W-1:0] fwd_mask_q, fwd_mask_d;
  logic [DATA_SRAM_DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic                        load_pending_q, load_pending_d;
  logic [DATA_SRAM_DATA_W-1:0] rdata_hold_q, rdata_hold_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[DATA_SRAM_ADDR_W-1:ADDR_WIDTH+2], data_sram_addr[1:0]};

  always_comb begin
    req   = classify_req(data_sram_en, data_sram_we);
    idx   = data_sram_addr[ADDR_WIDTH+1:2];
    drain = (req != REQ_LOAD) && stb_valid_q;

    // Loads own the port; otherwise the buffer drains. Nothing touches the array during reset.
    ram_en   = !reset && ((req == REQ_LOAD) || drain);
    ram_we   = (req == REQ_LOAD) ? '0 : stb_strb_q;
    ram_addr = (req == REQ_LOAD) ? idx : stb_idx_q;

    stb_valid_d = stb_valid_q;
    stb_idx_d   = stb_idx_q;
    stb_strb_d  = stb_strb_q;
    stb_data_d  = stb_data_q;
    fwd_mask_d  = fwd_mask_q;
    fwd_data_d  = fwd_data_q;

    case (req)
      REQ_STORE: begin
        stb_valid_d = 1'b1;
        stb_idx_d   = idx;
        stb_strb_d  = data_sram_we;
        stb_data_d  = data_sram_wdata;
      end
      REQ_LOAD: begin
        fwd_mask_d = stb_strb_q & {DATA_SRAM_STRB_W{stb_valid_q && (stb_idx_q == idx)}};
        fwd_data_d = stb_data_q;
      end
      default: stb_valid_d = 1'b0;
    endcase

    load_pending_d = (req == REQ_LOAD);
    merged         = merge_bytes(fwd_mask_q, fwd_data_q, ram_rdata);
    rdata_hold_d   = load_pending_q ? merged : rdata_hold_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stb_valid_q    <= 1'b0;
      stb_idx_q      <= '0;
      stb_strb_q     <= '0;
      stb_data_q     <= '0;
      fwd_mask_q     <= '0;
      fwd_data_q     <= '0;
      load_pending_q <= 1'b0;
      rdata_hold_q   <= '0;
    end else begin
      stb_valid_q    <= stb_valid_d;
      stb_idx_q      <= stb_idx_d;
      stb_strb_q     <= stb_strb_d;
      stb_data_q     <= stb_data_d;
      fwd_mask_q     <= fwd_mask_d;
      fwd_data_q     <= fwd_data_d;
      load_pending_q <= load_pending_d;
      rdata_hold_q   <= rdata_hold_d;
    end
  end

  sram_1rw_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(stb_data_q),
    .rdata(ram_rdata)
  );

  assign data_sram_rdata = load_pending_q ? merged : rdata_hold_q;
  assign stb_valid       = stb_valid_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stb_valid;

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int          n_cmp;
  int          n_bad;

  data_sram_responder #(.ADDR_WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .stb_valid      (stb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wd);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    n_cmp++;
    if (data_sram_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h want %h", data_sram_rdata, 32'h0);
    end
    n_cmp++;
    if (stb_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_stb_valid: got %b want 0", stb_valid);
    end
  endtask

  task automatic test_forward;
    cycle(1'b1, 4'hF, 32'h1000, 32'hDEADBEEF);
    n_cmp++;
    if (stb_valid !== 1'b1) begin
      n_bad++; $display("FAIL fwd_stb_set: got %b want 1", stb_valid);
    end
    exp_q.push_back(32'hDEADBEEF);
    cycle(1'b1, 4'h0, 32'h1000, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL fwd_load: got %h want %h", data_sram_rdata, exp);
    end
    n_cmp++;
    if (stb_valid !== 1'b1) begin
      n_bad++; $display("FAIL fwd_stb_held: got %b want 1", stb_valid);
    end
  endtask

  task automatic test_merge;
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++;
    if (stb_valid !== 1'b0) begin
      n_bad++; $display("FAIL merge_drained: got %b want 0", stb_valid);
    end
    cycle(1'b1, 4'b0010, 32'h1000, 32'h0000AB00);
    exp_q.push_back(32'hDEADABEF);
    cycle(1'b1, 4'h0, 32'h1000, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL merge_load: got %h want %h", data_sram_rdata, exp);
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b1, 4'hF, 32'h2000, 32'h11111111);
    cycle(1'b1, 4'hF, 32'h2004, 32'h22222222);
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++;
    if (stb_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drained: got %b want 0", stb_valid);
    end
    exp_q.push_back(32'h11111111);
    cycle(1'b1, 4'h0, 32'h2000, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL b2b_load0: got %h want %h", data_sram_rdata, exp);
    end
    exp_q.push_back(32'h22222222);
    cycle(1'b1, 4'h0, 32'h2004, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL b2b_load1: got %h want %h", data_sram_rdata, exp);
    end
    // Pending store to 0x2000 must not leak into a load of 0x2004.
    cycle(1'b1, 4'hF, 32'h2000, 32'h33333333);
    exp_q.push_back(32'h22222222);
    cycle(1'b1, 4'h0, 32'h2004, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL other_word_load: got %h want %h", data_sram_rdata, exp);
    end
    n_cmp++;
    if (stb_valid !== 1'b1) begin
      n_bad++; $display("FAIL other_word_stb: got %b want 1", stb_valid);
    end
    exp_q.push_back(32'h33333333);
    cycle(1'b1, 4'h0, 32'h2000, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL pending_fwd_load: got %h want %h", data_sram_rdata, exp);
    end
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_discard;
    cycle(1'b1, 4'hF, 32'h3000, 32'hAAAAAAAA);
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b1, 4'hF, 32'h3000, 32'h55555555);
    reset = 1'b1;
    cycle(1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    n_cmp++;
    if (data_sram_rdata !== 32'h0) begin
      n_bad++; $display("FAIL discard_rdata_reset: got %h want %h", data_sram_rdata, 32'h0);
    end
    exp_q.push_back(32'hAAAAAAAA);
    cycle(1'b1, 4'h0, 32'h3000, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL discard_load: got %h want %h", data_sram_rdata, exp);
    end
    n_cmp++;
    if (stb_valid !== 1'b0) begin
      n_bad++; $display("FAIL discard_stb: got %b want 0", stb_valid);
    end
  endtask

  task automatic test_alias_hold;
    exp_q.push_back(32'hDEADABEF);
    cycle(1'b1, 4'h0, 32'h1003, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL alias_low_bits: got %h want %h", data_sram_rdata, exp);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'h0, 32'h0000_2000 + 32'(i), 32'hFFFF_FFFF);
      n_cmp++;
      if (data_sram_rdata !== 32'hDEADABEF) begin
        n_bad++; $display("FAIL hold_idle_%0d: got %h want %h", i, data_sram_rdata, 32'hDEADABEF);
      end
    end
    exp_q.push_back(32'hDEADABEF);
    cycle(1'b1, 4'h0, 32'h0004_1000, 32'h0);
    exp = exp_q.pop_front();
    n_cmp++;
    if (data_sram_rdata !== exp) begin
      n_bad++; $display("FAIL alias_high_bits: got %h want %h", data_sram_rdata, exp);
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_bad           = 0;
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_forward();
    test_merge();
    test_back_to_back();
    test_reset_discard();
    test_alias_hold();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
